// File: rtl/ant_launcher.sv
// Ant-colony route discovery initiator: launches one forward ant at a time toward each
// other node in turn and converts the returning backward ant into a routing-table update.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif

package ant_pkg;
    localparam int X_NODES   = `X_NODES;
    localparam int Y_NODES   = `Y_NODES;
    localparam int XW        = (X_NODES > 1) ? $clog2(X_NODES) : 1;
    localparam int YW        = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;
    localparam int MEM_DEPTH = 8;
    localparam int NMW       = $clog2(MEM_DEPTH + 1);

    typedef struct packed {
        logic                          ant;
        logic                          backward;
        logic [XW-1:0]                 x_source;
        logic [YW-1:0]                 y_source;
        logic [XW-1:0]                 x_dest;
        logic [YW-1:0]                 y_dest;
        logic [MEM_DEPTH-1:0][XW-1:0]  x_memory;
        logic [MEM_DEPTH-1:0][YW-1:0]  y_memory;
        logic [NMW-1:0]                num_memory;
    } packet_t;
endpackage

module ant_launcher
    import ant_pkg::*;
#(
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    parameter int ANT_PERIOD = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          reset,
    output packet_t       o_data,
    output logic          o_data_val,
    input  logic          i_en,
    input  packet_t       i_data,
    input  logic          i_data_val,
    output logic          o_update_val,
    output logic [XW-1:0] o_update_x_dest,
    output logic [YW-1:0] o_update_y_dest,
    output logic [XW-1:0] o_update_x_next,
    output logic [YW-1:0] o_update_y_next,
    output logic [15:0]   o_update_rtt,
    output logic          o_timeout,
    output logic          o_drop
);
    localparam int NODES = X_NODES * Y_NODES;
    localparam int DW    = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int SELF  = Y_LOC * X_NODES + X_LOC;
    localparam int PW    = $clog2(ANT_PERIOD + 1);

    localparam logic [DW-1:0] SELF_IDX      = DW'(SELF);
    localparam logic [DW-1:0] FIRST_IDX     = DW'((SELF + 1) % NODES);
    localparam logic [PW-1:0] PERIOD_RELOAD = PW'(ANT_PERIOD - 1);
    localparam logic [15:0]   RTT_LIMIT     = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state, state_next;
    logic [PW-1:0] period_cnt;
    logic [DW-1:0] dest_idx, dest_adv;
    logic [15:0]   rtt_cnt;
    logic [XW-1:0] dest_x;
    logic [YW-1:0] dest_y;
    logic          is_bwd_ant, valid_ret, expire;
    logic          unused_data;

    function automatic logic [DW-1:0] step_idx(input logic [DW-1:0] idx);
        return (32'(idx) == 32'(NODES - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign unused_data = ^i_data;

    assign dest_x = XW'(32'(dest_idx) % 32'(X_NODES));
    assign dest_y = YW'(32'(dest_idx) / 32'(X_NODES));

    // Self is never a target, so a step landing on it takes one more step.
    always_comb begin
        dest_adv = step_idx(dest_idx);
        if (dest_adv == SELF_IDX)
            dest_adv = step_idx(dest_adv);
    end

    assign is_bwd_ant = i_data_val && i_data.ant && i_data.backward;
    assign valid_ret  = (state == WAIT) && is_bwd_ant
                     && (i_data.x_dest == XW'(X_LOC)) && (i_data.y_dest == YW'(Y_LOC))
                     && (i_data.x_source == dest_x) && (i_data.y_source == dest_y)
                     && (i_data.num_memory >= NMW'(2));
    assign expire     = (state == WAIT) && (rtt_cnt == RTT_LIMIT) && !valid_ret;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (period_cnt == '0) state_next = SEND;
            SEND:    if (i_en) state_next = WAIT;
            WAIT:    if (valid_ret || expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_data     = '0;
        o_data_val = 1'b0;
        if (state == SEND) begin
            o_data_val           = 1'b1;
            o_data.ant           = 1'b1;
            o_data.x_source      = XW'(X_LOC);
            o_data.y_source      = YW'(Y_LOC);
            o_data.x_dest        = dest_x;
            o_data.y_dest        = dest_y;
            o_data.x_memory[0]   = XW'(X_LOC);
            o_data.y_memory[0]   = YW'(Y_LOC);
            o_data.num_memory    = NMW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt      <= PERIOD_RELOAD;
            dest_idx        <= FIRST_IDX;
            rtt_cnt         <= '0;
            o_update_val    <= 1'b0;
            o_update_x_dest <= '0;
            o_update_y_dest <= '0;
            o_update_x_next <= '0;
            o_update_y_next <= '0;
            o_update_rtt    <= '0;
            o_timeout       <= 1'b0;
            o_drop          <= 1'b0;
        end else begin
            o_update_val <= valid_ret;
            o_timeout    <= expire;
            o_drop       <= is_bwd_ant && !valid_ret;
            case (state)
                IDLE: if (period_cnt != '0) period_cnt <= period_cnt - 1'b1;
                SEND: if (i_en) rtt_cnt <= '0;
                WAIT: begin
                    if (rtt_cnt != '1)
                        rtt_cnt <= rtt_cnt + 16'd1;
                    if (valid_ret || expire) begin
                        dest_idx   <= dest_adv;
                        period_cnt <= PERIOD_RELOAD;
                    end
                end
                default: ;
            endcase
            if (valid_ret) begin
                o_update_x_dest <= dest_x;
                o_update_y_dest <= dest_y;
                o_update_x_next <= i_data.x_memory[1];
                o_update_y_next <= i_data.y_memory[1];
                o_update_rtt    <= rtt_cnt;
            end
        end
    end
endmodule
